// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between the UART core and the command decoder.
// The master is the UART (receiver strobe plus transmitter busy); the slave is the decoder.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    output rx_data,
    output rx_done,
    output tx_busy,
    input  tx_data,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  tx_busy,
    output tx_data,
    output tx_start
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: digits select a mode, letters pulse start/pause/clear, other bytes count as errors.
// Define UART_CMD_ECHO_EN to build the one-entry acknowledge buffer and transmit handshake FSM.
module uart_cmd_decoder #(
  parameter int NUM_MODES    = 4,
  parameter int DEFAULT_MODE = 0,
  parameter int SEL_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter int ERR_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_cmd_decoder_if.slave    uart,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_changed,
  output logic                 start_pulse,
  output logic                 pause_pulse,
  output logic                 clear_pulse,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_BAD = 8'h3F;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_changed_q, sel_changed_d;
  logic             start_q, start_d;
  logic             pause_q, pause_d;
  logic             clear_q, clear_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             is_start, is_pause, is_clear, is_ctrl;
  logic [NUM_MODES-1:0] digit_hit;
  logic             digit_valid;
  logic [SEL_W-1:0] digit_sel;
  logic             byte_invalid;
  logic [7:0]       ack_new;

  assign is_start = (uart.rx_data == 8'h73) || (uart.rx_data == 8'h53);
  assign is_pause = (uart.rx_data == 8'h70) || (uart.rx_data == 8'h50);
  assign is_clear = (uart.rx_data == 8'h72) || (uart.rx_data == 8'h52);
  assign is_ctrl  = is_start || is_pause || is_clear;

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_digit
    assign digit_hit[gi] = (uart.rx_data == 8'(8'h30 + gi));
  end

  assign digit_valid  = |digit_hit;
  assign byte_invalid = !(is_ctrl || digit_valid);
  assign ack_new      = byte_invalid ? ACK_BAD : ACK_OK;

  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (digit_hit[i]) digit_sel = SEL_W'(i);
    end
  end

  // Only strobed bytes are decoded; every pulse defaults low so each lasts exactly one cycle.
  always_comb begin
    sel_d         = sel_q;
    sel_changed_d = 1'b0;
    start_d       = 1'b0;
    pause_d       = 1'b0;
    clear_d       = 1'b0;
    err_d         = err_q;
    if (uart.rx_done) begin
      if (is_start) begin
        start_d = 1'b1;
      end else if (is_pause) begin
        pause_d = 1'b1;
      end else if (is_clear) begin
        clear_d = 1'b1;
      end else if (digit_valid) begin
        sel_d         = digit_sel;
        sel_changed_d = (digit_sel != sel_q);
      end else if (err_q != {ERR_W{1'b1}}) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q         <= SEL_W'(DEFAULT_MODE);
      sel_changed_q <= 1'b0;
      start_q       <= 1'b0;
      pause_q       <= 1'b0;
      clear_q       <= 1'b0;
      err_q         <= '0;
    end else begin
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
      start_q       <= start_d;
      pause_q       <= pause_d;
      clear_q       <= clear_d;
      err_q         <= err_d;
    end
  end

  assign sel         = sel_q;
  assign sel_changed = sel_changed_q;
  assign start_pulse = start_q;
  assign pause_pulse = pause_q;
  assign clear_pulse = clear_q;
  assign err_count   = err_q;

`ifdef UART_CMD_ECHO_EN
  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_ARM  = 2'd1,
    ACK_BUSY = 2'd2
  } ack_state_e;

  ack_state_e state_q, state_d;
  logic       ack_pending_q, ack_pending_d;
  logic [7:0] ack_byte_q, ack_byte_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACK_IDLE;
      ack_pending_q <= 1'b0;
      ack_byte_q    <= 8'h00;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      ack_pending_q <= ack_pending_d;
      ack_byte_q    <= ack_byte_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACK_IDLE: if (ack_pending_q && !uart.tx_busy) state_d = ACK_ARM;
      ACK_ARM:  if (uart.tx_busy)                   state_d = ACK_BUSY;
      ACK_BUSY: if (!uart.tx_busy)                  state_d = ACK_IDLE;
      default:                                      state_d = ACK_IDLE;
    endcase
  end

  // A byte decoded in the issue cycle refills the buffer, so it is never dropped.
  always_comb begin
    issue         = (state_q == ACK_IDLE) && ack_pending_q && !uart.tx_busy;
    tx_start_d    = issue;
    tx_data_d     = issue ? ack_byte_q : tx_data_q;
    ack_pending_d = ack_pending_q && !issue;
    ack_byte_d    = ack_byte_q;
    if (uart.rx_done) begin
      ack_pending_d = 1'b1;
      ack_byte_d    = ack_new;
    end
  end

  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;
`else
  logic unused_echo;
  assign unused_echo   = uart.tx_busy ^ (^ack_new);
  assign uart.tx_start = 1'b0;
  assign uart.tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboarded bench for uart_cmd_decoder: two instances (4 modes/8-bit errors, 10 modes/2-bit errors)
// share random byte traffic; a reference model queues expected outputs and a monitor compares them.
module tb_uart_cmd_decoder;

  localparam int NM1 = 4,  DEF1 = 0, EW1 = 8, SW1 = 2;
  localparam int NM2 = 10, DEF2 = 7, EW2 = 2, SW2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if u1();
  uart_cmd_decoder_if u2();

  logic [SW1-1:0] sel1;
  logic           chg1, st1, pa1, cl1;
  logic [EW1-1:0] err1;
  logic [SW2-1:0] sel2;
  logic           chg2, st2, pa2, cl2;
  logic [EW2-1:0] err2;

  logic busy_drv = 1'b0;
  assign u1.tx_busy = busy_drv;
  assign u2.tx_busy = 1'b0;

  uart_cmd_decoder #(.NUM_MODES(NM1), .DEFAULT_MODE(DEF1), .ERR_W(EW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart(u1.slave),
    .sel(sel1), .sel_changed(chg1), .start_pulse(st1), .pause_pulse(pa1),
    .clear_pulse(cl1), .err_count(err1)
  );

  uart_cmd_decoder #(.NUM_MODES(NM2), .DEFAULT_MODE(DEF2), .ERR_W(EW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart(u2.slave),
    .sel(sel2), .sel_changed(chg2), .start_pulse(st2), .pause_pulse(pa2),
    .clear_pulse(cl2), .err_count(err2)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       chg;
    logic       st;
    logic       pa;
    logic       cl;
    logic [7:0] err;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: current mode and error count of each instance.
  int m_sel[2];
  int m_err[2];
  int m_nm[2]   = '{NM1, NM2};
  int m_def[2]  = '{DEF1, DEF2};
  int m_emax[2] = '{(1 << EW1) - 1, (1 << EW2) - 1};

  function automatic obs_t model_step(int i, bit rst_ok, bit done, int d);
    obs_t o;
    o = '0;
    if (!rst_ok) begin
      m_sel[i] = m_def[i];
      m_err[i] = 0;
    end else if (done) begin
      if (d == 8'h73 || d == 8'h53) o.st = 1'b1;
      else if (d == 8'h70 || d == 8'h50) o.pa = 1'b1;
      else if (d == 8'h72 || d == 8'h52) o.cl = 1'b1;
      else if (d >= 8'h30 && d - 8'h30 < m_nm[i]) begin
        o.chg    = ((d - 8'h30) != m_sel[i]);
        m_sel[i] = d - 8'h30;
      end else if (m_err[i] < m_emax[i]) begin
        m_err[i] = m_err[i] + 1;
      end
    end
    o.sel = 4'(m_sel[i]);
    o.err = 8'(m_err[i]);
    return o;
  endfunction

  task automatic cycle(input bit rst_ok, input bit done, input int d);
    exp_t e;
    rst_n      = rst_ok;
    u1.rx_done = done;
    u2.rx_done = done;
    u1.rx_data = done ? 8'(d) : 8'($urandom);
    u2.rx_data = u1.rx_data;
`ifndef UART_CMD_ECHO_EN
    busy_drv   = 1'($urandom);
`endif
    @(posedge clk);
    e.a = model_step(0, rst_ok, done, d);
    e.b = model_step(1, rst_ok, done, d);
    exp_q.push_back(e);
    if (done) $display("[TB] t=%0t rst_n=%0b byte=0x%02h", $time, rst_ok, d[7:0]);
    #1;
  endtask

  // Transmitter emulation and echo bookkeeping (echo build only).
  logic       hold_busy = 1'b0;
  int         busy_cnt  = 0;
  int         tx_cnt    = 0;
  logic [7:0] last_tx   = 8'h00;

  initial begin : monitor
    exp_t e;
    obs_t got_a, got_b;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        got_a = {2'b00, sel1, chg1, st1, pa1, cl1, err1};
        got_b = {sel2, chg2, st2, pa2, cl2, 6'b000000, err2};
        n_tests++;
        if (got_a !== e.a) begin
          n_fail++;
          $display("FAIL dut1_outputs t=%0t got=%h required=%h (sel,chg,start,pause,clear,err)", $time, got_a, e.a);
        end
        n_tests++;
        if (got_b !== e.b) begin
          n_fail++;
          $display("FAIL dut2_outputs t=%0t got=%h required=%h (sel,chg,start,pause,clear,err)", $time, got_b, e.b);
        end
`ifndef UART_CMD_ECHO_EN
        n_tests++;
        if ({u1.tx_start, u1.tx_data, u2.tx_start, u2.tx_data} !== 18'h0) begin
          n_fail++;
          $display("FAIL tx_tied_off t=%0t got start=%0b data=%h required 0/00", $time, u1.tx_start, u1.tx_data);
        end
`endif
      end
`ifdef UART_CMD_ECHO_EN
      if (u1.tx_start) begin
        n_tests++;
        if (u1.tx_busy) begin
          n_fail++;
          $display("FAIL tx_start_while_busy t=%0t got busy=1 required busy=0", $time);
        end
        tx_cnt   = tx_cnt + 1;
        last_tx  = u1.tx_data;
        busy_cnt = 4;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
      busy_drv = hold_busy || (busy_cnt != 0);
`endif
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  byte unsigned tbl[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h37, 8'h39, 8'h3A,
                            8'h53, 8'h73, 8'h50, 8'h70, 8'h52, 8'h72, 8'h41, 8'h2F};

  initial begin : stimulus
    int base;
    u1.rx_data = 8'h00; u1.rx_done = 1'b0;
    u2.rx_data = 8'h00; u2.rx_done = 1'b0;

    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 8'h32); cycle(1, 1, 8'h32); cycle(1, 0, 0);
    cycle(1, 1, 8'h35); cycle(1, 1, 8'h41); cycle(1, 0, 0);
    cycle(1, 1, 8'h53); cycle(1, 1, 8'h70); cycle(1, 1, 8'h72); cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'h3A);
    cycle(1, 1, 8'h39); cycle(1, 1, 8'h39); cycle(1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      bit rst_ok, done;
      int d;
      rst_ok = ($urandom_range(0, 63) != 0);
      done   = ($urandom_range(0, 9) < 6);
      d      = ($urandom_range(0, 1) == 1) ? int'(tbl[$urandom_range(0, 15)]) : int'($urandom_range(0, 255));
      cycle(rst_ok, done, d);
    end

`ifdef UART_CMD_ECHO_EN
    // Newest ack wins while the transmitter is held busy.
    hold_busy = 1'b1;
    repeat (3) cycle(0, 0, 0);
    base = tx_cnt;
    cycle(1, 1, 8'h31); cycle(1, 1, 8'h39);
    repeat (6) cycle(1, 0, 0);
    check_val("no_tx_while_busy", tx_cnt, base);
    hold_busy = 1'b0;
    repeat (12) cycle(1, 0, 0);
    check_val("single_tx_start", tx_cnt, base + 1);
    check_val("newest_ack_byte", int'(last_tx), 8'h3F);

    // Reset while the FSM is in BUSY aborts the handshake.
    base = tx_cnt;
    cycle(1, 1, 8'h53);
    for (int k = 0; k < 10 && tx_cnt == base; k++) cycle(1, 0, 0);
    check_val("ack_issued", tx_cnt, base + 1);
    check_val("ack_ok_byte", int'(last_tx), 8'h4B);
    repeat (2) cycle(0, 0, 0);
    check_val("tx_data_after_reset", int'(u1.tx_data), 0);
    repeat (15) cycle(1, 0, 0);
    check_val("no_tx_after_reset", tx_cnt, base + 1);
    check_val("sel_after_reset", int'(sel1), DEF1);
`else
    base = 0;
    check_val("echo_disabled_base", base + int'(u1.tx_start), 0);
`endif

    cycle(1, 0, 0);
    @(negedge clk);
    #1;
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
